jt900h_busctl: RTL and testbench

- Downstream memory-bus stage of the jt900h core: takes the core's 16-bit ram_addr/ram_din/ram_we/ram_dout port and bridges it to an external memory with a cs/ok handshake and arbitrary wait states.
- Stalls the core by gating its clock enable until each access completes.
- Keeps a one-word read buffer so repeated reads of the same halfword cost no bus cycle.

---
 rtl/jt900h_busctl_if.sv | 28 ++
 rtl/jt900h_busctl.sv | 144 ++++++++++++++
 tb/tb_jt900h_busctl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/jt900h_busctl_if.sv
// rtl/jt900h_busctl_if.sv - core-side and memory-side bus signals of jt900h_busctl
interface jt900h_busctl_if;
    // core side
    logic        cpu_cen;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_dout;
    // memory side
    logic [22:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_cs;
    logic [15:0] mem_dout;
    logic        mem_ok;

    // bridge view
    modport slave (
        output cpu_cen, cpu_dout, mem_addr, mem_din, mem_we, mem_cs,
        input  cpu_addr, cpu_din, cpu_we, mem_dout, mem_ok
    );

    // core plus memory view
    modport master (
        input  cpu_cen, cpu_dout, mem_addr, mem_din, mem_we, mem_cs,
        output cpu_addr, cpu_din, cpu_we, mem_dout, mem_ok
    );
endinterface

// File: rtl/jt900h_busctl.sv
// rtl/jt900h_busctl.sv - core memory bridge with cs/ok handshake, one-word read buffer; optional watchdog via JT900H_BUSCTL_TOUT_EN
module jt900h_busctl #(
    parameter int TOUT = 255
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic                  cen,
    jt900h_busctl_if.slave        bus,
    output logic                  bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [22:0] last_addr_q, last_addr_d;
    logic [15:0] dout_q, dout_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [1:0]  mem_we_q, mem_we_d;
    logic        mem_cs_q, mem_cs_d;
    logic        cpu_cen_c;
    logic        hit;
    logic        tout_fire;
    logic        wait_done;
    logic        timed_out;
    logic        unused_a0;

    // byte lanes come from cpu_we, so address bit 0 carries no information
    assign unused_a0 = bus.cpu_addr[0];

    assign hit = valid_q && (bus.cpu_addr[23:1] == last_addr_q) && (bus.cpu_we == 2'b00);

`ifdef JT900H_BUSCTL_TOUT_EN
    localparam int CW = $clog2(TOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          bus_err_q;

    // counter sits at zero outside WAIT, so every WAIT entry starts from zero
    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 1'b1;
    end

    // fires on the edge where the WAIT count would reach TOUT
    assign tout_fire = (state_q == WAIT) && (cnt_q == CW'(TOUT - 1));

    // one-cycle error pulse when the watchdog forces completion
    always_ff @(posedge clk) begin
        if (rst) bus_err_q <= 1'b0;
        else     bus_err_q <= tout_fire && !bus.mem_ok;
    end

    assign bus_err = bus_err_q;
`else
    localparam int unused_tout = TOUT;

    assign tout_fire = 1'b0;
    assign bus_err   = 1'b0;
`endif

    assign wait_done = bus.mem_ok || tout_fire;
    assign timed_out = tout_fire && !bus.mem_ok;

    // state and buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            last_addr_q <= '0;
            dout_q      <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= '0;
            mem_cs_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            last_addr_q <= last_addr_d;
            dout_q      <= dout_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_cs_q    <= mem_cs_d;
        end
    end

    // next-state, bus launch, buffer update and core enable gating
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        last_addr_d = last_addr_q;
        dout_d      = dout_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = mem_we_q;
        mem_cs_d    = mem_cs_q;
        cpu_cen_c   = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_cen_c = cen && hit;
                if (cen && !hit) begin
                    mem_addr_d = bus.cpu_addr[23:1];
                    mem_din_d  = bus.cpu_din;
                    mem_we_d   = bus.cpu_we;
                    mem_cs_d   = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    mem_cs_d = 1'b0;
                    mem_we_d = 2'b00;
                    state_d  = DONE;
                    if (mem_we_q == 2'b00) begin
                        dout_d      = timed_out ? 16'hFFFF : bus.mem_dout;
                        last_addr_d = mem_addr_q;
                        valid_d     = 1'b1;
                    end else if (valid_q && mem_addr_q == last_addr_q) begin
                        // write-through keeps the buffered halfword coherent
                        if (mem_we_q[1]) dout_d[15:8] = mem_din_q[15:8];
                        if (mem_we_q[0]) dout_d[7:0]  = mem_din_q[7:0];
                    end
                    // forced data must never be served as a hit
                    if (timed_out) valid_d = 1'b0;
                end
            end
            DONE: begin
                cpu_cen_c = cen;
                if (cen) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_cen  = cpu_cen_c && !rst;
    assign bus.cpu_dout = dout_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_cs   = mem_cs_q;

endmodule

// File: tb/tb_jt900h_busctl.sv
// tb/tb_jt900h_busctl.sv - scoreboard bench for jt900h_busctl
module tb_jt900h_busctl;

`ifdef JT900H_BUSCTL_TOUT_EN
    localparam int TOUT = 16;
`else
    localparam int TOUT = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    logic cen;
    logic bus_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    int          cs_n, pulse_at, berr_n;
    logic [22:0] seen_addr;
    logic [1:0]  seen_we;

    jt900h_busctl_if bus ();

    jt900h_busctl #(.TOUT(TOUT)) dut (
        .rst     (rst),
        .clk     (clk),
        .cen     (cen),
        .bus     (bus),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call at posedge+1. Drives one core access and plays memory: mem_ok is
    // raised on the ok_lat-th mem_cs cycle (0 = never). Stops at the first
    // cpu_cen and compares cpu_dout with the scoreboard head.
    task automatic access(input logic [23:0] a, input logic [1:0] we, input logic [15:0] din,
                          input int ok_lat, input logic [15:0] rdata, input logic [7:0] pat,
                          output int cs_o, output int pulse_o, output int berr_o,
                          output logic [22:0] addr_o, output logic [1:0] we_o);
        bus.cpu_addr = a;
        bus.cpu_we   = we;
        bus.cpu_din  = din;
        bus.mem_ok   = 1'b0;
        cen          = 1'b1;
        cs_o = 0; pulse_o = -1; berr_o = 0; addr_o = '0; we_o = '0;
        for (int i = 0; i < 60 && pulse_o < 0; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                cen = pat[(i - 1) % 8];
            end
            @(negedge clk);
            if (bus_err) berr_o++;
            if (bus.mem_cs) begin
                if (cs_o == 0) begin
                    addr_o = bus.mem_addr;
                    we_o   = bus.mem_we;
                end
                cs_o++;
                bus.mem_ok   = (ok_lat > 0) && (cs_o == ok_lat);
                bus.mem_dout = rdata;
            end else begin
                bus.mem_ok = 1'b0;
            end
            if (bus.cpu_cen) begin
                pulse_o = i;
                if (exp_q.size() > 0) check("dout", bus.cpu_dout, exp_q.pop_front());
                else                  check("sb_empty", exp_q.size(), 1);
            end
        end
        @(posedge clk); #1;
        cen        = 1'b0;
        bus.cpu_we = 2'b00;
        bus.mem_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0;
        bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_we = '0;
        bus.mem_dout = '0; bus.mem_ok = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_cen", bus.cpu_cen, 0);
        check("rst_mem_cs", bus.mem_cs, 0);
        check("rst_cpu_dout", bus.cpu_dout, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_bus_err", bus_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // first read misses, three wait states
        exp_q.push_back(16'h1234);
        access(24'h000100, 2'b00, 16'h0000, 3, 16'h1234, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("rd_cs_cycles", cs_n, 3);
        check("rd_pulse_at", pulse_at, 4);
        check("rd_mem_addr", seen_addr, 23'h000080);
        check("rd_mem_we", seen_we, 0);
        check("rd_bus_err", berr_n, 0);

        // same halfword hits: cpu_cen follows cen, no bus traffic
        bus.cpu_addr = 24'h000101;
        for (int k = 0; k < 4; k++) begin
            cen = (k % 2 == 0);
            @(negedge clk);
            check("hit_cen", bus.cpu_cen, cen);
            check("hit_cs", bus.mem_cs, 0);
            check("hit_dout", bus.cpu_dout, 16'h1234);
            @(posedge clk); #1;
        end
        cen = 1'b0;
        exp_q.push_back(16'h1234);
        access(24'h000101, 2'b00, 16'h0000, 0, 16'h0000, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("hit_cs_cycles", cs_n, 0);
        check("hit_pulse_at", pulse_at, 0);

        // upper-byte write-through into the buffered halfword
        exp_q.push_back(16'hAB34);
        access(24'h000100, 2'b10, 16'hAB00, 1, 16'hDEAD, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("wr_cs_cycles", cs_n, 1);
        check("wr_pulse_at", pulse_at, 2);
        check("wr_mem_we", seen_we, 2'b10);
        check("wr_mem_addr", seen_addr, 23'h000080);
        exp_q.push_back(16'hAB34);
        access(24'h000100, 2'b00, 16'h0000, 0, 16'h0000, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("wrhit_cs_cycles", cs_n, 0);
        check("wrhit_pulse_at", pulse_at, 0);

        // cen toggling, mem_ok lands on a cen=0 cycle, DONE waits for cen
        exp_q.push_back(16'h5A5A);
        access(24'h000400, 2'b00, 16'h0000, 1, 16'h5A5A, 8'h54, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("tog_cs_cycles", cs_n, 1);
        check("tog_pulse_at", pulse_at, 3);
        check("tog_mem_addr", seen_addr, 23'h000200);

        // reset during WAIT abandons the access and the buffer
        bus.cpu_addr = 24'h000600;
        cen = 1'b1;
        @(negedge clk);
        check("rw_miss_cen", bus.cpu_cen, 0);
        @(posedge clk); #1;
        cen = 1'b0;
        @(negedge clk);
        check("rw_cs_up", bus.mem_cs, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rw_cen_in_rst", bus.cpu_cen, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rw_cs_down", bus.mem_cs, 0);
        @(posedge clk); #1;
        exp_q.push_back(16'h1357);
        access(24'h000400, 2'b00, 16'h0000, 2, 16'h1357, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("rw_remiss_cs", cs_n, 2);
        check("rw_remiss_pulse", pulse_at, 3);

`ifdef JT900H_BUSCTL_TOUT_EN
        // silent memory: watchdog completes with all-ones, buffer not validated
        exp_q.push_back(16'hFFFF);
        access(24'h000300, 2'b00, 16'h0000, 0, 16'h0000, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("to_cs_cycles", cs_n, 16);
        check("to_pulse_at", pulse_at, 17);
        check("to_bus_err", berr_n, 1);
        @(negedge clk);
        check("to_err_drop", bus_err, 0);
        @(posedge clk); #1;
        exp_q.push_back(16'h0BEE);
        access(24'h000300, 2'b00, 16'h0000, 1, 16'h0BEE, 8'hFF, cs_n, pulse_at, berr_n, seen_addr, seen_we);
        check("to_remiss_cs", cs_n, 1);
        check("to_remiss_err", berr_n, 0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
